// File: rtl/regfile_dump.sv
// regfile_dump: walks a range of registers through one regfile read port and
// streams {address, data} beats over a valid/ready interface.
// Ports:
//   clk, reset            clock and synchronous active-low reset
//   start, abort          begin dump (IDLE only) / cancel dump (wins over all)
//   first_reg, last_reg   inclusive register range, latched on start
//   ra, rd                regfile read address / combinational read data
//   out_valid, out_ready  beat handshake
//   out_addr, out_data    register index and value of the current beat
//   busy                  dump in progress (RUN or DRAIN)
//   done                  one-cycle pulse after the last beat is accepted
module regfile_dump #(
   parameter int unsigned NREGS = 32,
   parameter int unsigned AW    = 5,
   parameter int unsigned DW    = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          abort,
   input  logic [AW-1:0] first_reg,
   input  logic [AW-1:0] last_reg,
   output logic [AW-1:0] ra,
   input  logic [DW-1:0] rd,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] out_addr,
   output logic [DW-1:0] out_data,
   output logic          busy,
   output logic          done
);

   // remaining counts up to NREGS, so it needs one bit more than an address
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } stateT;

   stateT         state, stateNext;
   logic [AW-1:0] ptr, ptrNext;
   logic [CW-1:0] remaining, remainingNext;
   logic          validNext;
   logic [AW-1:0] addrNext;
   logic [DW-1:0] dataNext;
   logic          busyNext;
   logic          doneNext;
   logic          load;

   // Read port follows the pointer only while fetching beats
   assign ra = (state == RUN) ? ptr : '0;

   // Next-state and next-output logic
   always_comb begin
      stateNext     = state;
      ptrNext       = ptr;
      remainingNext = remaining;
      validNext     = out_valid;
      addrNext      = out_addr;
      dataNext      = out_data;
      doneNext      = 1'b0;
      load          = !out_valid || out_ready;

      unique case (state)
         IDLE: begin
            // abort takes priority over a simultaneous start
            if (start && !abort) begin
               ptrNext       = first_reg;
               remainingNext = CW'((NREGS + 32'(last_reg) - 32'(first_reg)) % NREGS)
                               + CW'(1);
               stateNext     = RUN;
            end
         end
         RUN: begin
            if (abort) begin
               validNext = 1'b0;
               stateNext = IDLE;
            end else if (load) begin
               // output slot is free (or being emptied this edge): fetch next beat
               dataNext      = rd;
               addrNext      = ptr;
               validNext     = 1'b1;
               ptrNext       = AW'((32'(ptr) + 32'd1) % NREGS);
               remainingNext = remaining - CW'(1);
               if (remaining == CW'(1)) begin
                  stateNext = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (abort) begin
               validNext = 1'b0;
               stateNext = IDLE;
            end else if (out_valid && out_ready) begin
               validNext = 1'b0;
               doneNext  = 1'b1;
               stateNext = IDLE;
            end
         end
         default: begin
            validNext = 1'b0;
            stateNext = IDLE;
         end
      endcase

      busyNext = (stateNext != IDLE);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         ptr       <= '0;
         remaining <= '0;
         out_valid <= 1'b0;
         out_addr  <= '0;
         out_data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= stateNext;
         ptr       <= ptrNext;
         remaining <= remainingNext;
         out_valid <= validNext;
         out_addr  <= addrNext;
         out_data  <= dataNext;
         busy      <= busyNext;
         done      <= doneNext;
      end
   end

endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: directed bench for regfile_dump with a behavioural regfile.
module tb_regfile_dump;

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          abort;
   logic [AW-1:0] first_reg;
   logic [AW-1:0] last_reg;
   logic [AW-1:0] ra;
   logic [DW-1:0] rd;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_addr;
   logic [DW-1:0] out_data;
   logic          busy;
   logic          done;

   logic [DW-1:0] regs [32];
   logic [5:0]    readyPat;
   int            errors = 0;
   int            checks = 0;

   regfile_dump #(.NREGS(32), .AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .first_reg (first_reg),
      .last_reg  (last_reg),
      .ra        (ra),
      .rd        (rd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_addr  (out_addr),
      .out_data  (out_data),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   assign rd = regs[ra];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] expData(input int idx);
      logic [DW-1:0] v;
      v = DW'(idx) * 32'h0004_0101;
      return v;
   endfunction

   task automatic doStart(input int f, input int l);
      first_reg = AW'(f);
      last_reg  = AW'(l);
      start     = 1'b1;
      tick();
      start     = 1'b0;
      // range inputs must be ignored once the dump is running
      first_reg = AW'(f + 7);
      last_reg  = AW'(f + 9);
      chk("start_busy", 64'(busy), 64'd1);
      chk("start_valid0", 64'(out_valid), 64'd0);
      chk("start_ra", 64'(ra), 64'(f));
   endtask

   // Consume a dump, checking order, data, hold-while-stalled and done
   task automatic collect(input int f, input int nBeats, input bit stall);
      int            got = 0;
      int            cyc = 0;
      bit            held = 1'b0;
      bit            doneSeen = 1'b0;
      logic [AW-1:0] eAddr;
      while (!doneSeen && cyc < 300) begin
         out_ready = stall ? readyPat[cyc % 6] : 1'b1;
         eAddr = AW'((f + got) % 32);
         if (held) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_addr", 64'(out_addr), 64'(eAddr));
            chk("hold_data", 64'(out_data), 64'(expData(int'(eAddr))));
         end
         if (out_valid && out_ready) begin
            chk("beat_addr", 64'(out_addr), 64'(eAddr));
            chk("beat_data", 64'(out_data), 64'(expData(int'(eAddr))));
            got++;
         end
         if (done) begin
            chk("done_not_valid", 64'(out_valid), 64'd0);
            chk("done_not_busy", 64'(busy), 64'd0);
            doneSeen = 1'b1;
         end else begin
            held = out_valid && !out_ready;
            tick();
            cyc++;
         end
      end
      chk("beat_count", 64'(got), 64'(nBeats));
      chk("done_seen", 64'(doneSeen), 64'd1);
      out_ready = 1'b1;
      tick();
      chk("done_pulse_one", 64'(done), 64'd0);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = expData(i);
      readyPat  = 6'b101001;
      reset     = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      first_reg = '0;
      last_reg  = '0;
      out_ready = 1'b1;
      tick();
      tick();
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_addr", 64'(out_addr), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_ra", 64'(ra), 64'd0);
      reset = 1'b1;
      tick();

      // full dump, ready always high; first beat one edge after start
      doStart(0, 31);
      tick();
      chk("lat_valid", 64'(out_valid), 64'd1);
      chk("lat_addr", 64'(out_addr), 64'd0);
      chk("lat_data_r0", 64'(out_data), 64'd0);
      collect(0, 32, 1'b0);

      // full dump with back-pressure
      doStart(0, 31);
      collect(0, 32, 1'b1);

      // wrapping range
      doStart(30, 1);
      collect(30, 4, 1'b0);
      chk("wrap_busy_after", 64'(busy), 64'd0);

      // single register
      doStart(5, 5);
      tick();
      chk("one_data", 64'(out_data), 64'h0014_0505);
      collect(5, 1, 1'b0);

      // abort after third beat, with an ignored start while busy
      doStart(0, 31);
      tick();
      chk("ab_addr0", 64'(out_addr), 64'd0);
      start     = 1'b1;
      first_reg = AW'(10);
      last_reg  = AW'(12);
      tick();
      start     = 1'b0;
      chk("ab_addr1", 64'(out_addr), 64'd1);
      tick();
      chk("ab_addr2", 64'(out_addr), 64'd2);
      tick();
      chk("ab_addr3", 64'(out_addr), 64'd3);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("ab_valid", 64'(out_valid), 64'd0);
      chk("ab_busy", 64'(busy), 64'd0);
      chk("ab_done", 64'(done), 64'd0);
      tick();
      chk("ab_done_later", 64'(done), 64'd0);
      chk("ab_still_idle", 64'(busy), 64'd0);

      // abort beats start in IDLE
      start = 1'b1;
      abort = 1'b1;
      first_reg = AW'(0);
      last_reg  = AW'(3);
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("ab_vs_start_busy", 64'(busy), 64'd0);
      tick();
      chk("ab_vs_start_valid", 64'(out_valid), 64'd0);

      // reset mid-dump, then a fresh dump
      doStart(0, 31);
      tick();
      tick();
      chk("mid_addr1", 64'(out_addr), 64'd1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("mr_valid", 64'(out_valid), 64'd0);
      chk("mr_addr", 64'(out_addr), 64'd0);
      chk("mr_data", 64'(out_data), 64'd0);
      chk("mr_busy", 64'(busy), 64'd0);
      chk("mr_done", 64'(done), 64'd0);
      chk("mr_ra", 64'(ra), 64'd0);
      tick();
      chk("mr_no_done", 64'(done), 64'd0);
      doStart(2, 4);
      collect(2, 3, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
